// File: rtl/ascon_stream_sequencer.sv
// Streams associated data and plaintext words into an Ascon core one at a time,
// collects the returned ciphertext and tag, and guards every acknowledge wait with a timeout.
module ascon_stream_sequencer #(
   parameter int WORD_W   = 64,
   parameter int AD_WORDS = 1,
   parameter int PT_WORDS = 23,
   parameter int TIMEOUT  = 1023
) (
   input  logic                                                  clock_i,
   input  logic                                                  resetb_i,
   input  logic                                                  start_i,
   input  logic                                                  abort_i,
   input  logic [((AD_WORDS > 0) ? AD_WORDS*WORD_W : 1)-1:0]     ad_i,
   input  logic [PT_WORDS*WORD_W-1:0]                            pt_i,
   output logic                                                  ascon_start_o,
   output logic [WORD_W-1:0]                                     ascon_data_o,
   output logic                                                  ascon_data_valid_o,
   output logic                                                  ascon_associate_o,
   output logic                                                  ascon_final_o,
   input  logic                                                  end_init_i,
   input  logic                                                  end_assoc_i,
   input  logic                                                  end_cipher_i,
   input  logic                                                  end_tag_i,
   input  logic [WORD_W-1:0]                                     cipher_i,
   input  logic [127:0]                                          tag_i,
   output logic [PT_WORDS*WORD_W-1:0]                            ct_o,
   output logic [127:0]                                          tag_o,
   output logic                                                  busy_o,
   output logic                                                  done_o,
   output logic                                                  err_o
);

   localparam int CNT_W  = $clog2(((AD_WORDS > PT_WORDS) ? AD_WORDS : PT_WORDS) + 1);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  AD_LAST = CNT_W'((AD_WORDS > 0) ? AD_WORDS - 1 : 0);
   localparam logic [CNT_W-1:0]  PT_LAST = CNT_W'(PT_WORDS - 1);
   localparam logic [WAIT_W-1:0] TO_VAL  = WAIT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT_WAIT, S_AD_SEND, S_AD_WAIT, S_PT_SEND, S_PT_WAIT, S_DONE
   } state_t;

   state_t                    r_state, w_state_nxt;
   logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
   logic [WAIT_W-1:0]         r_wait;
   logic [WORD_W-1:0]         r_data, w_ad_word, w_pt_word, w_word_nxt;
   logic [PT_WORDS*WORD_W-1:0] r_ct;
   logic [127:0]              r_tag;
   logic                      r_start, r_err;
   logic                      w_go, w_timeout, w_cap, w_in_wait, w_last;

   assign w_last    = (r_cnt == PT_LAST);
   assign w_in_wait = (r_state == S_INIT_WAIT) || (r_state == S_AD_WAIT) || (r_state == S_PT_WAIT);
   // On the last word only end_tag_i completes it; an early end_cipher_i is not a capture.
   assign w_cap     = !abort_i && (r_state == S_PT_WAIT) && (w_last ? end_tag_i : end_cipher_i);
   assign w_go      = (r_state == S_IDLE) && (w_state_nxt == S_INIT_WAIT);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: if (start_i) begin
            w_state_nxt = S_INIT_WAIT;
            w_cnt_nxt   = '0;
         end
         S_INIT_WAIT: if (end_init_i) w_state_nxt = (AD_WORDS > 0) ? S_AD_SEND : S_PT_SEND;
         S_AD_SEND:   w_state_nxt = S_AD_WAIT;
         S_AD_WAIT: if (end_assoc_i) begin
            if (r_cnt == AD_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_PT_SEND;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
               w_state_nxt = S_AD_SEND;
            end
         end
         S_PT_SEND:   w_state_nxt = S_PT_WAIT;
         S_PT_WAIT: begin
            if (w_last) begin
               if (end_tag_i) w_state_nxt = S_DONE;
            end else if (end_cipher_i) begin
               w_cnt_nxt   = r_cnt + 1'b1;
               w_state_nxt = S_PT_SEND;
            end
         end
         S_DONE:      w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
      if (w_in_wait && (w_state_nxt == r_state) && (r_wait == TO_VAL)) begin
         w_state_nxt = S_IDLE;
         w_timeout   = 1'b1;
      end
      if (abort_i) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = r_cnt;
         w_timeout   = 1'b0;
      end
   end

   // Word muxes are indexed by the next count so the data register loads on SEND entry.
   always_comb begin
      w_pt_word = '0;
      for (int i = 0; i < PT_WORDS; i++)
         if (int'(w_cnt_nxt) == i) w_pt_word = pt_i[(PT_WORDS-1-i)*WORD_W +: WORD_W];
   end

   generate
      if (AD_WORDS > 0) begin : g_ad
         always_comb begin
            w_ad_word = '0;
            for (int i = 0; i < AD_WORDS; i++)
               if (int'(w_cnt_nxt) == i) w_ad_word = ad_i[(AD_WORDS-1-i)*WORD_W +: WORD_W];
         end
      end else begin : g_no_ad
         logic w_unused_ad;
         assign w_unused_ad = ^ad_i;
         assign w_ad_word   = '0;
      end
   endgenerate

   assign w_word_nxt = (w_state_nxt == S_AD_SEND) ? w_ad_word : w_pt_word;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_wait  <= '0;
         r_data  <= '0;
         r_start <= 1'b0;
         r_err   <= 1'b0;
         r_ct    <= '0;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wait  <= (w_in_wait && (w_state_nxt == r_state)) ? r_wait + 1'b1 : '0;
         r_start <= w_go;
         if ((w_state_nxt == S_AD_SEND) || (w_state_nxt == S_PT_SEND)) r_data <= w_word_nxt;
         if (w_go) begin
            r_ct  <= '0;
            r_tag <= '0;
            r_err <= 1'b0;
         end
         if (w_timeout) r_err <= 1'b1;
         if (w_cap) begin
            for (int i = 0; i < PT_WORDS; i++)
               if (int'(r_cnt) == i) r_ct[(PT_WORDS-1-i)*WORD_W +: WORD_W] <= cipher_i;
            if (w_last) r_tag <= tag_i;
         end
      end
   end

   assign ascon_start_o      = r_start;
   assign ascon_data_o       = r_data;
   assign ascon_data_valid_o = (r_state == S_AD_SEND) || (r_state == S_PT_SEND);
   assign ascon_associate_o  = (r_state == S_AD_SEND) || (r_state == S_AD_WAIT);
   assign ascon_final_o      = ((r_state == S_PT_SEND) || (r_state == S_PT_WAIT)) && w_last;
   assign ct_o               = r_ct;
   assign tag_o              = r_tag;
   assign busy_o             = (r_state != S_IDLE);
   assign done_o             = (r_state == S_DONE);
   assign err_o              = r_err;

endmodule

// File: tb/tb_ascon_stream_sequencer.sv
// Bench: 1 AD / 3 PT words against a 2-cycle Ascon model with a word scoreboard,
// plus a hand-driven 0 AD / 1 PT instance.
module tb_ascon_stream_sequencer;
   localparam logic [63:0] KEY = 64'h0123_4567_89AB_CDEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn, start, abort = 1'b0;
   logic [63:0] ad;
   logic [191:0] pt;
   logic a_start, a_valid, a_assoc, a_final;
   logic [63:0] a_data;
   logic end_init = 1'b0, end_assoc = 1'b0, end_cipher = 1'b0, end_tag = 1'b0;
   logic [63:0] cipher = '0;
   logic [127:0] tag_in = '0, tag_out;
   logic [191:0] ct;
   logic busy, done, err;

   ascon_stream_sequencer #(.WORD_W(64), .AD_WORDS(1), .PT_WORDS(3), .TIMEOUT(15)) dut (
      .clock_i(clk), .resetb_i(rstn), .start_i(start), .abort_i(abort), .ad_i(ad), .pt_i(pt),
      .ascon_start_o(a_start), .ascon_data_o(a_data), .ascon_data_valid_o(a_valid),
      .ascon_associate_o(a_assoc), .ascon_final_o(a_final),
      .end_init_i(end_init), .end_assoc_i(end_assoc), .end_cipher_i(end_cipher), .end_tag_i(end_tag),
      .cipher_i(cipher), .tag_i(tag_in), .ct_o(ct), .tag_o(tag_out),
      .busy_o(busy), .done_o(done), .err_o(err));

   logic b_start, b_ad, b_ascon_start, b_valid, b_assoc, b_final, b_init, b_endtag;
   logic [63:0] b_pt, b_data, b_cipher, b_ct;
   logic [127:0] b_tag_in, b_tag_out;
   logic b_busy, b_done, b_err, b_assoc_seen = 1'b0;

   ascon_stream_sequencer #(.WORD_W(64), .AD_WORDS(0), .PT_WORDS(1)) dut0 (
      .clock_i(clk), .resetb_i(rstn), .start_i(b_start), .abort_i(1'b0), .ad_i(b_ad), .pt_i(b_pt),
      .ascon_start_o(b_ascon_start), .ascon_data_o(b_data), .ascon_data_valid_o(b_valid),
      .ascon_associate_o(b_assoc), .ascon_final_o(b_final),
      .end_init_i(b_init), .end_assoc_i(1'b0), .end_cipher_i(1'b0), .end_tag_i(b_endtag),
      .cipher_i(b_cipher), .tag_i(b_tag_in), .ct_o(b_ct), .tag_o(b_tag_out),
      .busy_o(b_busy), .done_o(b_done), .err_o(b_err));

   int n_chk = 0, n_fail = 0, n_done = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct packed { logic [63:0] data; logic assoc; logic fin; } exp_t;
   exp_t exp_q[$];

   // Ascon model knobs, written by the main sequence
   bit k_hold = 1'b0, k_spur = 1'b0;
   int k_abort_idx = -1;

   // Ascon model + scoreboard monitor: acks two cycles after each request
   int m_kind = 0, m_delay = 0, m_idx = 0, m_cur = 0;
   logic [63:0] m_word = '0;
   always @(negedge clk) begin
      end_init = 1'b0; end_assoc = 1'b0; end_cipher = 1'b0; end_tag = 1'b0; abort = 1'b0;
      if (done) n_done++;
      if (b_assoc) b_assoc_seen = 1'b1;
      if (m_kind != 0) begin
         m_delay--;
         if (m_kind == 4 && m_delay == 1) begin
            end_cipher = 1'b1;
            cipher = ~(m_word ^ KEY);
         end
         if (m_kind == 3 && m_delay == 1 && k_spur) end_assoc = 1'b1;
         if (m_delay == 0) begin
            case (m_kind)
               1: end_init = 1'b1;
               2: end_assoc = 1'b1;
               3: if (!k_hold) begin
                  end_cipher = 1'b1;
                  cipher = m_word ^ KEY;
                  if (m_cur == k_abort_idx) abort = 1'b1;
               end
               default: begin
                  end_tag = 1'b1;
                  cipher = m_word ^ KEY;
                  tag_in = {m_word, ~m_word};
               end
            endcase
            m_kind = 0;
         end
      end
      if (a_start) begin
         m_kind = 1; m_delay = 2; m_idx = 0;
      end else if (a_valid) begin
         if (exp_q.size() == 0) chk("sb_unexpected_word", 256'(a_data), 256'(0));
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_data", 256'(a_data), 256'(e.data));
            chk("sb_assoc", 256'(a_assoc), 256'(e.assoc));
            chk("sb_final", 256'(a_final), 256'(e.fin));
         end
         m_word = a_data;
         if (a_assoc) m_kind = 2;
         else begin
            m_cur = m_idx; m_idx++;
            m_kind = a_final ? 4 : 3;
         end
         m_delay = 2;
      end
   end

   task automatic push_exp(input logic [63:0] va, input logic [191:0] vp);
      exp_q.push_back({va, 1'b1, 1'b0});
      exp_q.push_back({vp[191:128], 1'b0, 1'b0});
      exp_q.push_back({vp[127:64], 1'b0, 1'b0});
      exp_q.push_back({vp[63:0], 1'b0, 1'b1});
   endtask

   function automatic logic [191:0] exp_ct(input logic [191:0] vp);
      return {vp[191:128] ^ KEY, vp[127:64] ^ KEY, vp[63:0] ^ KEY};
   endfunction

   task automatic run_enc(input string nm, input logic [63:0] va, input logic [191:0] vp,
                          input logic [191:0] ect, input logic [127:0] etag, input bit busy_start);
      int d0;
      bit got;
      ad = va; pt = vp;
      push_exp(va, vp);
      d0 = n_done;
      start = 1'b1; @(negedge clk); start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
         start = (busy_start && c == 6);
         @(negedge clk);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk({nm, "_done_seen"}, 256'(got), 256'(1));
      chk({nm, "_ct"}, 256'(ct), 256'(ect));
      chk({nm, "_tag"}, 256'(tag_out), 256'(etag));
      chk({nm, "_err"}, 256'(err), 256'(0));
      repeat (3) @(negedge clk);
      chk({nm, "_idle"}, 256'(busy), 256'(0));
      chk({nm, "_one_done"}, 256'(n_done), 256'(d0 + 1));
      chk({nm, "_sb_drained"}, 256'(exp_q.size()), 256'(0));
   endtask

   typedef struct {
      logic [63:0]  ad;
      logic [191:0] pt;
      logic [191:0] ct;
      logic [127:0] tag;
      bit           busy_start;
      bit           spur;
   } vec_t;
   vec_t vt[4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      bit seen;
      vt[0] = '{64'h0, 192'h0, '0, '0, 1'b0, 1'b0};
      vt[1] = '{{64{1'b1}}, {192{1'b1}}, '0, '0, 1'b1, 1'b0};
      vt[2] = '{64'hDEAD_BEEF_0000_0001, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                64'h9999_AAAA_BBBB_CCCC}, '0, '0, 1'b0, 1'b1};
      vt[3] = '{{$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                '0, '0, 1'b1, 1'b1};
      foreach (vt[i]) begin
         vt[i].ct  = exp_ct(vt[i].pt);
         vt[i].tag = {vt[i].pt[63:0], ~vt[i].pt[63:0]};
      end

      rstn = 1'b0; start = 1'b0; ad = '0; pt = '0;
      b_start = 1'b0; b_ad = 1'b0; b_pt = 64'hFEED_FACE_CAFE_0042; b_init = 1'b0; b_endtag = 1'b0;
      b_cipher = '0; b_tag_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_done", 256'(done), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      chk("rst_ct", 256'(ct), 256'(0));
      chk("rst_tag", 256'(tag_out), 256'(0));
      chk("rst_data", 256'(a_data), 256'(0));
      chk("rst_pulses", 256'({a_start, a_valid, a_assoc, a_final}), 256'(0));
      rstn = 1'b1;
      @(negedge clk);

      foreach (vt[i]) begin
         k_spur = vt[i].spur;
         run_enc($sformatf("vec%0d", i), vt[i].ad, vt[i].pt, vt[i].ct, vt[i].tag, vt[i].busy_start);
      end
      k_spur = 1'b0;

      // Timeout: cipher ack for word 0 withheld
      k_hold = 1'b1;
      ad = vt[2].ad; pt = vt[2].pt;
      push_exp(ad, pt);
      d0 = n_done;
      start = 1'b1; @(negedge clk); start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (a_valid && !a_assoc) seen = 1'b1;
      end
      chk("to_pt_send_seen", 256'(seen), 256'(1));
      repeat (16) @(negedge clk);
      chk("to_err_early", 256'(err), 256'(0));
      chk("to_busy_early", 256'(busy), 256'(1));
      @(negedge clk);
      chk("to_err_set", 256'(err), 256'(1));
      chk("to_busy_clr", 256'(busy), 256'(0));
      repeat (3) @(negedge clk);
      chk("to_no_done", 256'(n_done), 256'(d0));
      chk("to_ct_empty", 256'(ct), 256'(0));
      exp_q.delete();
      k_hold = 1'b0;

      // Abort together with the cipher ack of word 1
      k_abort_idx = 1;
      ad = vt[2].ad; pt = vt[2].pt;
      push_exp(ad, pt);
      d0 = n_done;
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("ab_err_cleared", 256'(err), 256'(0));
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (!busy) seen = 1'b1;
      end
      chk("ab_idle", 256'(seen), 256'(1));
      chk("ab_ct_partial", 256'(ct), 256'({vt[2].pt[191:128] ^ KEY, 128'h0}));
      repeat (3) @(negedge clk);
      chk("ab_no_done", 256'(n_done), 256'(d0));
      exp_q.delete();
      k_abort_idx = -1;

      // Reset during AD_WAIT, then a full run
      ad = vt[2].ad; pt = vt[2].pt;
      push_exp(ad, pt);
      start = 1'b1; @(negedge clk); start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (a_assoc && !a_valid) seen = 1'b1;
      end
      chk("rs_ad_wait_seen", 256'(seen), 256'(1));
      rstn = 1'b0;
      #1;
      chk("rs_data", 256'(a_data), 256'(0));
      chk("rs_flags", 256'({busy, done, err, a_start, a_valid, a_assoc, a_final}), 256'(0));
      chk("rs_ct_tag", 256'({ct, tag_out}), 256'(0));
      @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      d0 = n_done;
      repeat (5) @(negedge clk);
      chk("rs_no_done", 256'(n_done), 256'(d0));
      chk("rs_idle", 256'(busy), 256'(0));
      run_enc("rs_rerun", vt[3].ad, vt[3].pt, vt[3].ct, vt[3].tag, 1'b0);

      // No-AD single-word instance
      b_start = 1'b1; @(negedge clk); b_start = 1'b0;
      chk("b_start_pulse", 256'(b_ascon_start), 256'(1));
      @(negedge clk);
      b_init = 1'b1; @(negedge clk); b_init = 1'b0;
      chk("b_valid", 256'(b_valid), 256'(1));
      chk("b_data", 256'(b_data), 256'(b_pt));
      chk("b_final", 256'(b_final), 256'(1));
      @(negedge clk);
      chk("b_final_hold", 256'({b_final, b_valid, b_done}), 256'(3'b100));
      b_endtag = 1'b1; b_cipher = 64'h0BAD_F00D_1234_5678; b_tag_in = {64'h77, 64'h99};
      @(negedge clk);
      b_endtag = 1'b0;
      chk("b_done", 256'(b_done), 256'(1));
      chk("b_ct", 256'(b_ct), 256'(64'h0BAD_F00D_1234_5678));
      chk("b_tag", 256'(b_tag_out), 256'({64'h77, 64'h99}));
      @(negedge clk);
      chk("b_idle", 256'({b_busy, b_done, b_err}), 256'(0));
      chk("b_assoc_never", 256'(b_assoc_seen), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
